// File: rtl/dem_xung_bcd.sv
// Synchronises an asynchronous pulse into clki, detects its rising edges and counts them in
// NDIG-digit BCD (up/down, loadable, enable-gated). Define DEM_XUNG_SAT_EN for saturation.
module dem_xung_bcd #(
    parameter int unsigned NDIG = 2
) (
    input  logic              clki,
    input  logic              rst,
    input  logic              xung_in,
    input  logic              E,
    input  logic              up_dn,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_val,
    output logic [4*NDIG-1:0] bcd,
    output logic              tc
);

    logic              sync1, sync2, prev;
    logic              step;
    logic              all9, all0, at_limit;
    logic              carry, borrow;
    logic [3:0]        digit, ld;
    logic [4*NDIG-1:0] up_val, dn_val, clamp_val;

    assign step     = sync2 & ~prev;
    assign at_limit = up_dn ? all9 : all0;

    always_comb begin
        up_val    = '0;
        dn_val    = '0;
        clamp_val = '0;
        all9      = 1'b1;
        all0      = 1'b1;
        carry     = 1'b1;
        borrow    = 1'b1;
        digit     = '0;
        ld        = '0;
        for (int i = 0; i < NDIG; i++) begin
            digit = bcd[4*i +: 4];
            if (digit != 4'd9) all9 = 1'b0;
            if (digit != 4'd0) all0 = 1'b0;

            // Ripple increment: a 9 rolls to 0 and passes the carry on
            if (!carry) begin
                up_val[4*i +: 4] = digit;
            end else if (digit == 4'd9) begin
                up_val[4*i +: 4] = 4'd0;
            end else begin
                up_val[4*i +: 4] = digit + 4'd1;
                carry            = 1'b0;
            end

            if (!borrow) begin
                dn_val[4*i +: 4] = digit;
            end else if (digit == 4'd0) begin
                dn_val[4*i +: 4] = 4'd9;
            end else begin
                dn_val[4*i +: 4] = digit - 4'd1;
                borrow           = 1'b0;
            end

            ld                  = load_val[4*i +: 4];
            clamp_val[4*i +: 4] = (ld > 4'd9) ? 4'd9 : ld;
        end
    end

    always_ff @(posedge clki) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            bcd   <= '0;
            tc    <= 1'b0;
        end else begin
            // The sync chain always runs so re-enabling never sees a stale edge
            sync1 <= xung_in;
            sync2 <= sync1;
            prev  <= sync2;
            tc    <= 1'b0;
            if (load) begin
                bcd <= clamp_val;
            end else if (step && E) begin
                tc <= at_limit;
`ifdef DEM_XUNG_SAT_EN
                if (!at_limit) bcd <= up_dn ? up_val : dn_val;
`else
                bcd <= up_dn ? up_val : dn_val;
`endif
            end
        end
    end

endmodule

// File: tb/tb_dem_xung_bcd.sv
// Randomised bench for dem_xung_bcd with an integer-count reference model and directed
// scenarios. Define DEM_XUNG_SAT_EN to check the saturating build.
module tb_dem_xung_bcd;

    localparam int NDIG = 2;
    localparam int W    = 4 * NDIG;
    localparam int MOD  = 10 ** NDIG;

    logic         clki;
    logic         rst, xung_in, E, up_dn, load;
    logic [W-1:0] load_val;
    logic [W-1:0] bcd;
    logic         tc;

    dem_xung_bcd #(.NDIG(NDIG)) dut (
        .clki    (clki),
        .rst     (rst),
        .xung_in (xung_in),
        .E       (E),
        .up_dn   (up_dn),
        .load    (load),
        .load_val(load_val),
        .bcd     (bcd),
        .tc      (tc)
    );

    initial clki = 1'b0;
    always #10 clki = ~clki;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: count as a plain integer, xung_in samples kept in a 3-deep history
    int m_cnt = 0;
    bit m_tc  = 0;
    bit hist[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int clamp_int(input logic [W-1:0] v);
        int r, p, d;
        r = 0;
        p = 1;
        for (int i = 0; i < NDIG; i++) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            r = r + d * p;
            p = p * 10;
        end
        return r;
    endfunction

    task automatic tick;
        bit edge_seen;
        @(posedge clki);
        if (rst) begin
            m_cnt = 0;
            m_tc  = 0;
            hist[0] = 0; hist[1] = 0; hist[2] = 0;
        end else begin
            // A rising edge seen two samples ago that was low three samples ago
            edge_seen = hist[1] && !hist[2];
            m_tc = 0;
            if (load) begin
                m_cnt = clamp_int(load_val);
            end else if (edge_seen && E) begin
                if (up_dn) begin
                    if (m_cnt == MOD - 1) begin
                        m_tc = 1;
`ifndef DEM_XUNG_SAT_EN
                        m_cnt = 0;
`endif
                    end else m_cnt = m_cnt + 1;
                end else begin
                    if (m_cnt == 0) begin
                        m_tc = 1;
`ifndef DEM_XUNG_SAT_EN
                        m_cnt = MOD - 1;
`endif
                    end else m_cnt = m_cnt - 1;
                end
            end
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = xung_in;
        end
        @(negedge clki);
        check("bcd", 32'(bcd), 32'(to_bcd(m_cnt)));
        check("tc", 32'(tc), 32'(m_tc));
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        for (int k = 0; k < n; k++) begin
            xung_in = 1'b1;
            repeat (hi) tick();
            xung_in = 1'b0;
            repeat (lo) tick();
        end
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load     = 1'b1;
        load_val = v;
        tick();
        load = 1'b0;
    endtask

    int run;

    initial begin
        rst = 1'b1; xung_in = 1'b0; E = 1'b1; up_dn = 1'b1; load = 1'b0; load_val = '0;

        // 1: reset, first-change latency, five up pulses
        repeat (2) tick();
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_tc", 32'(tc), 32'h0);
        rst = 1'b0;
        xung_in = 1'b1;
        tick(); tick();
        check("lat_hold", 32'(bcd), 32'h0);
        tick();
        check("lat_first", 32'(bcd), 32'h1);
        tick();
        xung_in = 1'b0;
        repeat (4) tick();
        pulses(4, 4, 4);
        check("t1_five", 32'(bcd), 32'h05);

        // 2: wrap/saturate upward
        do_load(8'h98);
        check("t2_load", 32'(bcd), 32'h98);
        pulses(2, 4, 4);
`ifdef DEM_XUNG_SAT_EN
        check("t2_final", 32'(bcd), 32'h99);
`else
        check("t2_final", 32'(bcd), 32'h00);
`endif

        // 3: wrap/saturate downward
        up_dn = 1'b0;
        do_load(8'h01);
        pulses(2, 4, 4);
`ifdef DEM_XUNG_SAT_EN
        check("t3_final", 32'(bcd), 32'h00);
`else
        check("t3_final", 32'(bcd), 32'h99);
`endif

        // 4: disabled counting, then enable while the pulse is already high
        up_dn = 1'b1;
        do_load(8'h42);
        E = 1'b0;
        pulses(10, 3, 3);
        xung_in = 1'b1;
        repeat (4) tick();
        E = 1'b1;
        repeat (4) tick();
        xung_in = 1'b0;
        repeat (4) tick();
        check("t4_hold", 32'(bcd), 32'h42);

        // 5: clamp on load; load beats a simultaneous step
        do_load(8'hAF);
        check("t5_clamp", 32'(bcd), 32'h99);
        do_load(8'h10);
        xung_in = 1'b1;
        tick(); tick();
        do_load(8'h63);
        check("t5_load_wins", 32'(bcd), 32'h63);
        repeat (3) tick();
        xung_in = 1'b0;
        repeat (4) tick();
        check("t5_after", 32'(bcd), 32'h63);

        // 6: reset with a step pending in the sync chain
        do_load(8'h37);
        xung_in = 1'b1;
        tick(); tick();
        rst = 1'b1;
        xung_in = 1'b0;
        tick();
        check("t6_rst", 32'(bcd), 32'h00);
        rst = 1'b0;
        repeat (5) tick();
        check("t6_drop", 32'(bcd), 32'h00);

        // Random traffic
        run = 2;
        for (int c = 0; c < 4000; c++) begin
            if (run == 0) begin
                xung_in = ~xung_in;
                run = $urandom_range(1, 4);
            end else begin
                run--;
            end
            rst  = ($urandom_range(0, 249) == 0);
            load = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 3))
                0: load_val = to_bcd(MOD - 1 - int'($urandom_range(0, 2)));
                1: load_val = to_bcd(int'($urandom_range(0, 2)));
                default: for (int i = 0; i < NDIG; i++) load_val[4*i +: 4] = 4'($urandom_range(0, 15));
            endcase
            E = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
